// File: rtl/axis_iq_demod_pkg.sv
// Shared constants and types for the AXI-Stream I/Q demodulator.
// Field positions describe the packed NCO word {2'b0, SINE, 2'b0, COS}.
package axis_iq_demod_pkg;

  localparam int NCO_TDATA_WIDTH = 32;
  localparam int ADC_TDATA_WIDTH = 16;
  localparam int OUT_WIDTH       = 32;
  localparam int IQ_TDATA_WIDTH  = 2 * OUT_WIDTH;
  localparam int SIN_LSB         = 16;
  localparam int COS_LSB         = 0;

  typedef struct packed {
    logic signed [OUT_WIDTH-1:0] q;
    logic signed [OUT_WIDTH-1:0] i;
  } iq_word_t;

endpackage

// File: rtl/axis_iq_demod_if.sv
// Stream bundle between the demodulator and its environment.
// The slave modport is the demodulator's view; master is the environment's.
interface axis_iq_demod_if;
  import axis_iq_demod_pkg::*;

  logic [NCO_TDATA_WIDTH-1:0] S_AXIS_NCO_TDATA;
  logic                       S_AXIS_NCO_TVALID;
  logic [ADC_TDATA_WIDTH-1:0] S_AXIS_ADC_TDATA;
  logic                       S_AXIS_ADC_TVALID;
  logic [IQ_TDATA_WIDTH-1:0]  M_AXIS_IQ_TDATA;
  logic                       M_AXIS_IQ_TVALID;
  logic                       M_AXIS_IQ_TREADY;
  logic                       OVERRUN;

  modport slave (
    input  S_AXIS_NCO_TDATA, S_AXIS_NCO_TVALID,
    input  S_AXIS_ADC_TDATA, S_AXIS_ADC_TVALID,
    input  M_AXIS_IQ_TREADY,
    output M_AXIS_IQ_TDATA, M_AXIS_IQ_TVALID, OVERRUN
  );

  modport master (
    output S_AXIS_NCO_TDATA, S_AXIS_NCO_TVALID,
    output S_AXIS_ADC_TDATA, S_AXIS_ADC_TVALID,
    output M_AXIS_IQ_TREADY,
    input  M_AXIS_IQ_TDATA, M_AXIS_IQ_TVALID, OVERRUN
  );

endinterface

// File: rtl/axis_iq_demod_mac_channel.sv
// One demodulator arm: registered product, block accumulator and truncated mean.
// The accumulator is wide enough that a full block of extreme products cannot overflow.
module iq_mac_channel
  import axis_iq_demod_pkg::*;
#(
  parameter int AMPLITUDE_BITS = 14,
  parameter int ADC_BITS       = 14,
  parameter int DECIM_LOG2     = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic signed [ADC_BITS-1:0]       sample_i,
  input  logic signed [AMPLITUDE_BITS-1:0] ref_i,
  input  logic                             prod_en_i,
  input  logic                             acc_en_i,
  input  logic                             dump_i,
  output logic signed [OUT_WIDTH-1:0]      mean_o
);

  localparam int PROD_W = ADC_BITS + AMPLITUDE_BITS;
  localparam int ACC_W  = PROD_W + DECIM_LOG2;

  logic signed [PROD_W-1:0]    prod_q, prod_d;
  logic signed [ACC_W-1:0]     acc_q, acc_d;
  logic signed [ACC_W-1:0]     sum, shifted;
  logic signed [OUT_WIDTH-1:0] mean_q, mean_d;

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    prod_d  = prod_q;
    acc_d   = acc_q;
    mean_d  = mean_q;
    sum     = acc_q + ACC_W'(prod_q);
    shifted = sum >>> DECIM_LOG2;
    if (prod_en_i) prod_d = sample_i * ref_i;
    if (acc_en_i) begin
      if (dump_i) begin
        acc_d  = '0;
        mean_d = OUT_WIDTH'(shifted);
      end else begin
        acc_d = sum;
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      acc_q  <= '0;
      mean_q <= '0;
    end else begin
      prod_q <= prod_d;
      acc_q  <= acc_d;
      mean_q <= mean_d;
    end
  end

  assign mean_o = mean_q;

endmodule

// File: rtl/axis_iq_demod.sv
// I/Q demodulator: multiplies ADC samples by NCO cos/sin and outputs block means.
// Pipeline: input register, product, accumulate/dump, output register with handshake.
module axis_iq_demod
  import axis_iq_demod_pkg::*;
#(
  parameter int AMPLITUDE_BITS = 14,
  parameter int ADC_BITS       = 14,
  parameter int DECIM_LOG2     = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  axis_iq_demod_if.slave      axis_if
);

  localparam logic [DECIM_LOG2-1:0] CNT_LAST = '1;

  logic                             accept;
  logic                             s1_valid_q, s1_valid_d;
  logic signed [AMPLITUDE_BITS-1:0] s1_sin_q, s1_sin_d;
  logic signed [AMPLITUDE_BITS-1:0] s1_cos_q, s1_cos_d;
  logic signed [ADC_BITS-1:0]       s1_adc_q, s1_adc_d;
  logic                             s2_valid_q, s2_valid_d;
  logic [DECIM_LOG2-1:0]            cnt_q, cnt_d;
  logic                             dump;
  logic                             dump_q, dump_d;
  logic signed [OUT_WIDTH-1:0]      mean_i, mean_q;
  iq_word_t                         tdata_q, tdata_d;
  logic                             tvalid_q, tvalid_d;
  logic                             overrun_q, overrun_d;
  logic                             unused_tdata_bits;

  assign accept = axis_if.S_AXIS_NCO_TVALID && axis_if.S_AXIS_ADC_TVALID;
  assign dump   = s2_valid_q && (cnt_q == CNT_LAST);
  // Padding bits of both input words are don't-care.
  assign unused_tdata_bits = ^{axis_if.S_AXIS_NCO_TDATA, axis_if.S_AXIS_ADC_TDATA};

  always_comb begin
    s1_valid_d = accept;
    s1_sin_d   = s1_sin_q;
    s1_cos_d   = s1_cos_q;
    s1_adc_d   = s1_adc_q;
    if (accept) begin
      s1_sin_d = axis_if.S_AXIS_NCO_TDATA[SIN_LSB +: AMPLITUDE_BITS];
      s1_cos_d = axis_if.S_AXIS_NCO_TDATA[COS_LSB +: AMPLITUDE_BITS];
      s1_adc_d = axis_if.S_AXIS_ADC_TDATA[ADC_BITS-1:0];
    end
    s2_valid_d = s1_valid_q;
    cnt_d      = s2_valid_q ? cnt_q + DECIM_LOG2'(1) : cnt_q;
    dump_d     = dump;
  end

  iq_mac_channel #(
    .AMPLITUDE_BITS(AMPLITUDE_BITS), .ADC_BITS(ADC_BITS), .DECIM_LOG2(DECIM_LOG2)
  ) u_chan_i (
    .clk(clk), .rst_n(rst_n), .sample_i(s1_adc_q), .ref_i(s1_cos_q),
    .prod_en_i(s1_valid_q), .acc_en_i(s2_valid_q), .dump_i(dump), .mean_o(mean_i)
  );

  iq_mac_channel #(
    .AMPLITUDE_BITS(AMPLITUDE_BITS), .ADC_BITS(ADC_BITS), .DECIM_LOG2(DECIM_LOG2)
  ) u_chan_q (
    .clk(clk), .rst_n(rst_n), .sample_i(s1_adc_q), .ref_i(s1_sin_q),
    .prod_en_i(s1_valid_q), .acc_en_i(s2_valid_q), .dump_i(dump), .mean_o(mean_q)
  );

  // A new block result wins over a pending one; losing an unread result is sticky.
  always_comb begin
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    overrun_d = overrun_q;
    if (tvalid_q && axis_if.M_AXIS_IQ_TREADY) tvalid_d = 1'b0;
    if (dump_q) begin
      tdata_d  = '{q: mean_q, i: mean_i};
      tvalid_d = 1'b1;
      if (tvalid_q && !axis_if.M_AXIS_IQ_TREADY) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sin_q   <= '0;
      s1_cos_q   <= '0;
      s1_adc_q   <= '0;
      s2_valid_q <= 1'b0;
      cnt_q      <= '0;
      dump_q     <= 1'b0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sin_q   <= s1_sin_d;
      s1_cos_q   <= s1_cos_d;
      s1_adc_q   <= s1_adc_d;
      s2_valid_q <= s2_valid_d;
      cnt_q      <= cnt_d;
      dump_q     <= dump_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign axis_if.M_AXIS_IQ_TDATA  = tdata_q;
  assign axis_if.M_AXIS_IQ_TVALID = tvalid_q;
  assign axis_if.OVERRUN          = overrun_q;

endmodule

// File: tb/tb_axis_iq_demod.sv
// Bench for axis_iq_demod: a 4-sample-block instance driven by directed and random
// pairs against a block-mean model, plus a 2^16-sample instance for worst-case range.
module tb_axis_iq_demod;

  logic clk;
  logic rst_n;
  logic rst16_n;
  int   n_cmp;
  int   n_fail;

  // Reference model: running sums of accepted pairs, mean taken every 4 pairs.
  longint sum_i, sum_q, exp_i, exp_q;
  int     n_acc;

  axis_iq_demod_if bus ();
  axis_iq_demod_if bus16 ();

  axis_iq_demod #(.AMPLITUDE_BITS(14), .ADC_BITS(14), .DECIM_LOG2(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .axis_if(bus)
  );

  axis_iq_demod #(.AMPLITUDE_BITS(14), .ADC_BITS(14), .DECIM_LOG2(16)) u_dut16 (
    .clk(clk), .rst_n(rst16_n), .axis_if(bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint floor_div4(input longint s);
    longint q = s / 4;
    if ((s % 4) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    sum_i = 0;
    sum_q = 0;
    n_acc = 0;
  endtask

  task automatic model_accept(input int adc, input int cos_v, input int sin_v);
    sum_i += longint'(adc) * cos_v;
    sum_q += longint'(adc) * sin_v;
    n_acc++;
    if (n_acc == 4) begin
      exp_i = floor_div4(sum_i);
      exp_q = floor_div4(sum_q);
      model_reset();
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int adc, input int cos_v, input int sin_v,
                       input bit v_nco, input bit v_adc);
    logic [13:0] a14, c14, s14;
    a14 = adc[13:0];
    c14 = cos_v[13:0];
    s14 = sin_v[13:0];
    bus.S_AXIS_NCO_TDATA  = {2'($urandom), s14, 2'($urandom), c14};
    bus.S_AXIS_ADC_TDATA  = {2'($urandom), a14};
    bus.S_AXIS_NCO_TVALID = v_nco;
    bus.S_AXIS_ADC_TVALID = v_adc;
    step();
    if (v_nco && v_adc) model_accept(adc, cos_v, sin_v);
  endtask

  task automatic idle();
    bus.S_AXIS_NCO_TVALID = 1'b0;
    bus.S_AXIS_ADC_TVALID = 1'b0;
  endtask

  task automatic block4(input int adc, input int cos_v, input int sin_v);
    for (int i = 0; i < 4; i++) drive(adc, cos_v, sin_v, 1'b1, 1'b1);
    idle();
  endtask

  task automatic wait_valid(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles && bus.M_AXIS_IQ_TVALID !== 1'b1; i++) step();
    check({tag, ".tvalid"}, bus.M_AXIS_IQ_TVALID, 1);
  endtask

  task automatic check_data(input string tag);
    check({tag, ".i"}, $signed(bus.M_AXIS_IQ_TDATA[31:0]), exp_i);
    check({tag, ".q"}, $signed(bus.M_AXIS_IQ_TDATA[63:32]), exp_q);
  endtask

  task automatic consume(input string tag);
    bus.M_AXIS_IQ_TREADY = 1'b1;
    step();
    bus.M_AXIS_IQ_TREADY = 1'b0;
    check({tag, ".cleared"}, bus.M_AXIS_IQ_TVALID, 0);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    exp_i  = 0;
    exp_q  = 0;
    model_reset();
    rst_n   = 1'b0;
    rst16_n = 1'b0;
    bus.S_AXIS_NCO_TDATA   = '0;
    bus.S_AXIS_ADC_TDATA   = '0;
    bus.S_AXIS_NCO_TVALID  = 1'b0;
    bus.S_AXIS_ADC_TVALID  = 1'b0;
    bus.M_AXIS_IQ_TREADY   = 1'b0;
    // Worst case for the long block: -8192 * -8192 on every sample.
    bus16.S_AXIS_NCO_TDATA  = {2'b0, 14'd0, 2'b0, 14'h2000};
    bus16.S_AXIS_ADC_TDATA  = 16'h2000;
    bus16.S_AXIS_NCO_TVALID = 1'b1;
    bus16.S_AXIS_ADC_TVALID = 1'b1;
    bus16.M_AXIS_IQ_TREADY  = 1'b0;

    // Reset state
    step();
    step();
    check("rst.tvalid", bus.M_AXIS_IQ_TVALID, 0);
    check("rst.tdata", $signed(bus.M_AXIS_IQ_TDATA), 0);
    check("rst.overrun", bus.OVERRUN, 0);
    check("rst16.tvalid", bus16.M_AXIS_IQ_TVALID, 0);
    rst_n   = 1'b1;
    rst16_n = 1'b1;

    // Basic block with latency: TVALID rises exactly three edges after the 4th pair
    block4(1000, 8191, 0);
    check("lat.k0", bus.M_AXIS_IQ_TVALID, 0);
    step();
    check("lat.k1", bus.M_AXIS_IQ_TVALID, 0);
    step();
    check("lat.k2", bus.M_AXIS_IQ_TVALID, 0);
    step();
    check("lat.k3", bus.M_AXIS_IQ_TVALID, 1);
    check_data("basic");
    check("basic.i_const", $signed(bus.M_AXIS_IQ_TDATA[31:0]), 8191000);
    step();
    check("hold.tvalid", bus.M_AXIS_IQ_TVALID, 1);
    check_data("hold");
    consume("basic");

    // Negative ADC and sine
    block4(-1000, 8191, -8191);
    wait_valid("neg", 12);
    check_data("neg");
    check("neg.q_const", $signed(bus.M_AXIS_IQ_TDATA[63:32]), 8191000);
    consume("neg");

    // ADC valid on alternate cycles only
    for (int i = 0; i < 8; i++) drive(1000, 8191, 0, 1'b1, (i % 2) == 0);
    idle();
    wait_valid("gap", 12);
    check_data("gap");
    consume("gap");

    // Random values with random valid gaps on both streams
    for (int b = 0; b < 8; b++) begin
      for (int c = 0; c < 4 && n_acc == 0; c++) begin end
      for (int c = 0; c < 200; c++) begin
        int  adc, cs, sn;
        bit  last;
        adc  = (b == 0) ? -8192 : int'($urandom_range(0, 16383)) - 8192;
        cs   = (b == 0) ? -8192 : int'($urandom_range(0, 16383)) - 8192;
        sn   = (b == 0) ? 8191  : int'($urandom_range(0, 16383)) - 8192;
        last = (n_acc == 3);
        drive(adc, cs, sn, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        if (last && n_acc == 0) break;
      end
      idle();
      wait_valid("rand", 12);
      check_data("rand");
      consume("rand");
    end

    // Two dumps with TREADY low: second result overwrites and OVERRUN sets
    block4(500, 3000, -2000);
    wait_valid("ovr.a", 12);
    block4(-700, -100, 8000);
    step();
    step();
    step();
    check("ovr.tvalid", bus.M_AXIS_IQ_TVALID, 1);
    check_data("ovr.b");
    check("ovr.flag", bus.OVERRUN, 1);
    step();
    check("ovr.sticky", bus.OVERRUN, 1);

    // Reset mid-block while a result is pending
    drive(4000, 5000, 6000, 1'b1, 1'b1);
    drive(4000, 5000, 6000, 1'b1, 1'b1);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst.tvalid", bus.M_AXIS_IQ_TVALID, 0);
    check("mrst.tdata", $signed(bus.M_AXIS_IQ_TDATA), 0);
    check("mrst.overrun", bus.OVERRUN, 0);
    model_reset();
    step();
    rst_n = 1'b1;

    // First result after reset uses only post-reset pairs
    for (int i = 0; i < 4; i++) drive(-300 * (i + 1), 7000 - i * 1000, 200 * i, 1'b1, 1'b1);
    idle();
    wait_valid("post", 12);
    check_data("post");

    // Dump coinciding with a transfer: new data, TVALID stays, no OVERRUN
    block4(2500, -4000, 3333);
    step();
    step();
    bus.M_AXIS_IQ_TREADY = 1'b1;
    step();
    bus.M_AXIS_IQ_TREADY = 1'b0;
    check("xfer.tvalid", bus.M_AXIS_IQ_TVALID, 1);
    check_data("xfer");
    check("xfer.overrun", bus.OVERRUN, 0);
    consume("xfer");

    // Long block at extreme magnitude
    for (int i = 0; i < 70000 && bus16.M_AXIS_IQ_TVALID !== 1'b1; i++) step();
    check("d16.tvalid", bus16.M_AXIS_IQ_TVALID, 1);
    check("d16.i", $signed(bus16.M_AXIS_IQ_TDATA[31:0]), 67108864);
    check("d16.q", $signed(bus16.M_AXIS_IQ_TDATA[63:32]), 0);
    check("d16.overrun", bus16.OVERRUN, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_iq_demod.md
AXIS_IQ_DEMOD -- requirements
Module: axis_iq_demod

Interface
REQ-001 SHALL have parameter AMPLITUDE_BITS, default 14: signed width of the NCO sine and cosine fields.
REQ-002 SHALL have parameter ADC_BITS, default 14: signed width of the ADC sample.
REQ-003 SHALL have parameter DECIM_LOG2, default 8, legal range 1..16: log2 of the number of samples per output.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port S_AXIS_NCO_TDATA, input, 32 bits: {2'b0, SINE[13:0], 2'b0, COS[13:0]}, both fields signed.
REQ-007 SHALL have port S_AXIS_NCO_TVALID, input, 1 bit: NCO word valid.
REQ-008 SHALL have port S_AXIS_ADC_TDATA, input, 16 bits: signed sample in bits [ADC_BITS-1:0]; upper bits ignored.
REQ-009 SHALL have port S_AXIS_ADC_TVALID, input, 1 bit: ADC sample valid.
REQ-010 SHALL have port M_AXIS_IQ_TDATA, output, 64 bits: {Q[31:0], I[31:0]}, signed.
REQ-011 SHALL have port M_AXIS_IQ_TVALID, output, 1 bit: result valid.
REQ-012 SHALL have port M_AXIS_IQ_TREADY, input, 1 bit: downstream accepts.
REQ-013 SHALL have port OVERRUN, output, 1 bit: sticky flag, set when an unconsumed result was overwritten.

Function
REQ-014 SHALL treat a sample pair as accepted on a rising edge when S_AXIS_NCO_TVALID and S_AXIS_ADC_TVALID are both 1.
REQ-015 SHALL drop any cycle with either input TVALID low, without advancing any counter; the inputs have no TREADY.
REQ-016 Stage 1 SHALL register the unpacked SINE, COS and ADC values together with a valid bit.
REQ-017 Stage 2 SHALL register the full-precision signed products P_I = ADC*COS and P_Q = ADC*SIN, each ADC_BITS+AMPLITUDE_BITS bits wide.
REQ-018 Stage 3 SHALL accumulate valid products into signed accumulators of width ADC_BITS+AMPLITUDE_BITS+DECIM_LOG2; this width SHALL never overflow.
REQ-019 SHALL count valid products with a DECIM_LOG2-bit counter that wraps from 2^DECIM_LOG2-1 to 0.
REQ-020 On a valid product while the counter is 2^DECIM_LOG2-1 (a dump), the block SHALL:
 - form sum = accumulator + product;
 - load each output word with sum arithmetically shifted right by DECIM_LOG2 (truncated mean), sign-extended or truncated to 32 bits;
 - clear the accumulator to 0;
 - set M_AXIS_IQ_TVALID.
REQ-021 Latency SHALL be 3 edges: if the final sample of a block is accepted at edge k, TVALID is 1 after edge k+3.
REQ-022 M_AXIS_IQ_TVALID and M_AXIS_IQ_TDATA SHALL stay stable until a cycle with TVALID=1 and TREADY=1; TVALID then clears unless a dump occurs in the same cycle.
REQ-023 A dump in the same cycle as a TVALID&TREADY transfer SHALL load the new data and keep TVALID at 1; OVERRUN is not set.
REQ-024 A dump while TVALID=1 and TREADY=0 SHALL overwrite TDATA, keep TVALID at 1, and set OVERRUN.
REQ-025 OVERRUN SHALL remain set until reset.

Reset
REQ-026 While rst_n=0, all pipeline registers, accumulators, the counter, M_AXIS_IQ_TDATA, M_AXIS_IQ_TVALID and OVERRUN SHALL be 0, taking effect asynchronously.
REQ-027 Reset in the middle of a block SHALL discard the partial sum; the first accepted pair after release starts a new block of 2^DECIM_LOG2 samples.

Structure
REQ-028 Package axis_iq_demod_pkg SHALL hold the TDATA field positions (SIN_LSB=16, COS_LSB=0), ADC_TDATA_WIDTH=16 and OUT_WIDTH=32.
REQ-029 SHALL instantiate sub-module iq_mac_channel (multiply, accumulate, dump) twice, once for I and once for Q; the counter and the output handshake SHALL be shared.

Verification
REQ-030 DECIM_LOG2=2, ADC=1000, COS=8191, SIN=0, both TVALID held 1 -> one result per 4 pairs with I=8191000 and Q=0; the first TVALID appears 3 edges after the 4th pair.
REQ-031 ADC=-1000, SIN=-8191, COS=8191 -> Q=8191000 and I=-8191000.
REQ-032 Deassert S_AXIS_ADC_TVALID on alternate cycles -> results unchanged; one output per 4 accepted pairs.
REQ-033 TREADY held 0 across two dumps -> TDATA holds the second result, TVALID=1, OVERRUN=1; with TREADY pulsed at each dump cycle, OVERRUN stays 0.
REQ-034 Assert rst_n=0 after 2 of 4 samples, then release -> all outputs 0 during reset; the next result equals the mean of the 4 post-reset pairs only.
REQ-035 ADC=-8192, COS=-8192, DECIM_LOG2=16 -> I=67108864 with no accumulator overflow.
